rs_slot_allocator: RTL
======================

# rs_slot_allocator

Tracks the occupancy of the reservation-station entries and grants the lowest-numbered free entry to dispatch each cycle. It holds a busy bitmap, encodes the inverted bitmap with a lowest-set-bit priority search, and offers the result on a valid/ready allocation handshake. Issue returns entries on a release port. The block sits between rename/dispatch, which requests entries, and the reservation-station storage, which is written at the granted index.

## Interface
- `ENTRY_NUM`, default 16: number of entries; power of two, at least 2.
- `IDX_WIDTH`, default 4: width of an entry index; equals log2(`ENTRY_NUM`).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `flush_i` in 1: pipeline flush; frees every entry.
- `alloc_req_i` in 1: dispatch requests one entry this cycle.
- `alloc_ready_o` out 1: at least one entry is free.
- `alloc_idx_o` out `IDX_WIDTH`: lowest free index; 0 when `alloc_ready_o`=0.
- `release_valid_i` in 1: one entry is returned this cycle.
- `release_idx_i` in `IDX_WIDTH`: index of the returned entry.
- `free_count_o` out `IDX_WIDTH`+1: number of free entries.
- `full_o` out 1: no free entry (`free_count_o`=0).
- `empty_o` out 1: all entries free (`free_count_o`=`ENTRY_NUM`).

## Operation
- State:
  - `busy[ENTRY_NUM-1:0]` register.
  - `free_cnt` register, `IDX_WIDTH`+1 bits.
- Free vector is `~busy`. The priority search returns the lowest set position and an any-set flag.
  - `alloc_ready_o` = any-set flag.
  - `alloc_idx_o` = position, gated to 0 when not ready.
- Allocation fires when `alloc_req_i` && `alloc_ready_o`. On the next edge, `busy[alloc_idx_o]` is set.
- A request while full is not an error. Nothing changes, and dispatch holds the request.
- Release fires when `release_valid_i` && `busy[release_idx_i]`. On the next edge, `busy[release_idx_i]` is cleared.
- Release of a non-busy entry is ignored: no bitmap change, no count change.
- Same-cycle allocate and release:
  - Both are applied.
  - The count change is +1 per effective release and −1 per fired allocation, so the net is 0 when both take effect.
  - A release cannot target `alloc_idx_o`, because that entry is free and the release is therefore ignored. The allocation still sets it busy.
- `flush_i` has priority over allocate and release:
  - Next edge: `busy`=0, `free_cnt`=`ENTRY_NUM`.
  - Same-cycle alloc/release are discarded.
- Invariant: `free_cnt` always equals the popcount of `~busy`. `free_cnt` stays in [0, `ENTRY_NUM`] and never wraps.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `busy`=0, `free_count_o`=`ENTRY_NUM`.
  - `alloc_ready_o`=1, `alloc_idx_o`=0.
  - `full_o`=0, `empty_o`=1.
- Outputs are combinational from registered state only. No input-to-output combinational path.
- Allocation latency: the grant is valid in the request cycle. The next cycle's `alloc_idx_o` already reflects the new busy bit.
- Release latency: a released entry is allocatable the cycle after `release_valid_i`.
- Flush: all outputs show the reset values in the cycle after `flush_i`.
- Reset asserted mid-operation clears the state immediately. The first grant after `rst_n` rises is index 0.

## Configuration
- `RS_SLOT_ALLOC_CHECK_EN`
  - Defined:
    - Adds output `err_o`, 1 bit, reset 0.
    - `err_o` is a sticky flag set on the edge after `release_valid_i` names a non-busy entry.
    - It is also set on the edge after `alloc_req_i` while `full_o`=1 and `flush_i`=0.
    - Only `rst_n` clears it; flush does not.
  - Undefined: the port and its logic are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset, then `alloc_req_i`=1 for 4 cycles with `ENTRY_NUM`=4 -> `alloc_idx_o` = 0,1,2,3 in successive cycles. Then `full_o`=1, `alloc_ready_o`=0, `alloc_idx_o`=0, `free_count_o`=0.
- Full with `ENTRY_NUM`=4, release index 1 -> next cycle `alloc_idx_o`=1, `free_count_o`=1. Alloc then gives `full_o`=1 again.
- Busy = 4'b0101, same cycle alloc (grants 1) and release 2 -> busy = 4'b0011, `free_count_o` unchanged at 2, next grant index 2.
- Release index 3 while busy = 4'b0001 -> no change, `free_count_o`=3. With `RS_SLOT_ALLOC_CHECK_EN` defined, `err_o`=1 and it stays 1 after a later `flush_i`.
- Busy = 4'b1011, `flush_i` together with alloc and release 0 -> next cycle busy=0, `free_count_o`=4, `empty_o`=1, `alloc_idx_o`=0.
- `rst_n` dropped asynchronously mid-allocation with busy = 4'b0111 -> outputs go to reset values before the next edge, and the first grant after release of reset is 0.

Source files
------------

// File: rtl/rs_slot_allocator.sv
// Reservation-station slot allocator: busy bitmap, lowest-free-entry grant, release port, free count.
// Optional RS_SLOT_ALLOC_CHECK_EN adds a sticky err_o for ignored releases and requests while full.
module rs_slot_allocator #(
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 alloc_req_i,
    output logic                 alloc_ready_o,
    output logic [IDX_WIDTH-1:0] alloc_idx_o,
    input  logic                 release_valid_i,
    input  logic [IDX_WIDTH-1:0] release_idx_i,
    output logic [IDX_WIDTH:0]   free_count_o,
    output logic                 full_o,
    output logic                 empty_o
`ifdef RS_SLOT_ALLOC_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    localparam int unsigned CNT_W = IDX_WIDTH + 1;

    logic [ENTRY_NUM-1:0] busy;
    logic [ENTRY_NUM-1:0] busy_nxt;
    logic [CNT_W-1:0]     free_cnt;
    logic [CNT_W-1:0]     free_cnt_nxt;
    logic [ENTRY_NUM-1:0] free_vec;
    logic [IDX_WIDTH-1:0] search_pos;
    logic                 search_any;
    logic                 alloc_fire;
    logic                 rel_fire;

    assign free_vec = ~busy;

    // Lowest-set-bit search over the free vector.
    always_comb begin
        search_any = 1'b0;
        search_pos = '0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            if (free_vec[i] && !search_any) begin
                search_any = 1'b1;
                search_pos = IDX_WIDTH'(i);
            end
        end
    end

    assign alloc_ready_o = search_any;
    assign alloc_idx_o   = search_any ? search_pos : '0;
    assign free_count_o  = free_cnt;
    assign full_o        = (free_cnt == '0);
    assign empty_o       = (free_cnt == CNT_W'(ENTRY_NUM));

    assign alloc_fire = alloc_req_i && alloc_ready_o;
    assign rel_fire   = release_valid_i && busy[release_idx_i];

    // The allocated entry is free, so an effective release can never hit it.
    always_comb begin
        busy_nxt     = busy;
        free_cnt_nxt = free_cnt;
        if (flush_i) begin
            busy_nxt     = '0;
            free_cnt_nxt = CNT_W'(ENTRY_NUM);
        end else begin
            if (alloc_fire) begin
                busy_nxt[alloc_idx_o] = 1'b1;
            end
            if (rel_fire) begin
                busy_nxt[release_idx_i] = 1'b0;
            end
            free_cnt_nxt = free_cnt + CNT_W'(rel_fire) - CNT_W'(alloc_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            free_cnt <= CNT_W'(ENTRY_NUM);
        end else begin
            busy     <= busy_nxt;
            free_cnt <= free_cnt_nxt;
        end
    end

`ifdef RS_SLOT_ALLOC_CHECK_EN
    logic err_set;

    assign err_set = (release_valid_i && !busy[release_idx_i])
                   || (alloc_req_i && full_o && !flush_i);

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (err_set) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule
